dmem_unit: RTL and testbench

Parametrised data-memory stage for the pipelined MIPS core: accepts one load/store request at a time over a valid/ready handshake. It owns a synchronous-read word RAM and performs sub-word stores (sb/sh) as a two-cycle read-modify-write. It returns sign/zero-extended load data for lb/lbu/lh/lhu/lw and flags misaligned accesses instead of corrupting memory.

---
 rtl/dmem_unit.sv | 89 ++++++++
 tb/tb_dmem_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// dmem_unit: data-memory stage with sub-word RMW stores, extended loads and misalignment flagging
module dmem_unit #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rdata_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] misalign_addr
);
  localparam int IW = ADDR_W - 2;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;
  state_t state, state_nx;
  logic [31:0] mem [0:2**IW-1];
  logic [31:0] rd_q, hold_q, ext, merged, wd;
  logic [5:0]  op_q;
  logic [1:0]  off_q, bl;
  logic [15:0] wdata_q, h;
  logic [7:0]  b;
  logic [IW-1:0] idx, idx_q, wa;
  logic accept, is_load, is_sub, is_sw, mis, re, we, hl;
  assign idx         = req_addr[ADDR_W-1:2];
  assign req_ready   = state == IDLE;
  assign accept      = req_valid & req_ready;
  assign rdata_valid = state == LOAD;
  assign rdata       = state == LOAD ? ext : hold_q;
  // decode the request, pick lanes for the latched access, and build load/merge data
  always_comb begin
    is_load  = req_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_sub   = req_op inside {OP_SB, OP_SH};
    is_sw    = req_op == OP_SW;
    mis      = ((req_op inside {OP_LH, OP_LHU, OP_SH}) && req_addr[0]) ||
               ((req_op inside {OP_LW, OP_SW}) && req_addr[1:0] != 2'b00);
    re       = accept & ~mis & (is_load | is_sub);
    we       = (accept & ~mis & is_sw) | (state == RMW);
    state_nx = re ? (is_load ? LOAD : RMW) : IDLE;
    bl       = BIG_ENDIAN ? ~off_q : off_q;
    hl       = BIG_ENDIAN ? ~off_q[1] : off_q[1];
    b        = rd_q[{bl, 3'b000} +: 8];
    h        = rd_q[{hl, 4'b0000} +: 16];
    ext      = op_q == OP_LW  ? rd_q :
               op_q == OP_LB  ? {{24{b[7]}}, b} :
               op_q == OP_LBU ? {24'b0, b} :
               op_q == OP_LH  ? {{16{h[15]}}, h} : {16'b0, h};
    merged   = rd_q;
    if (op_q == OP_SB) merged[{bl, 3'b000} +: 8] = wdata_q[7:0];
    else merged[{hl, 4'b0000} +: 16] = wdata_q;
    wa       = state == RMW ? idx_q : idx;
    wd       = state == RMW ? merged : req_wdata;
  end
  // control state, latched request fields and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_q        <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      op_q          <= '0;
      off_q         <= '0;
      wdata_q       <= '0;
      idx_q         <= '0;
    end else begin
      state    <= state_nx;
      misalign <= accept & mis;
      if (accept & mis) misalign_addr <= req_addr;
      if (re) begin
        op_q    <= req_op;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
        idx_q   <= idx;
      end
      if (state == LOAD) hold_q <= ext;
    end
  end
  // word RAM: synchronous write, registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd_q <= mem[idx];
  end
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: scoreboard bench driving little- and big-endian instances with identical requests
module tb_dmem_unit;
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
  logic [5:0] req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic le_ready, le_rv, le_mis, be_ready, be_rv, be_mis;
  logic [31:0] le_rdata, le_maddr, be_rdata, be_maddr;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] ble [0:1023];
  logic [7:0] bbe [0:1023];
  typedef struct {string tag; int cyc; logic [31:0] le; logic [31:0] be;} exp_t;
  exp_t rq[$];
  exp_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_unit #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(le_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata_valid(le_rv), .rdata(le_rdata),
    .misalign(le_mis), .misalign_addr(le_maddr));
  dmem_unit #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(be_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata_valid(be_rv), .rdata(be_rdata),
    .misalign(be_mis), .misalign_addr(be_maddr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld(input bit be, input logic [5:0] op, input logic [31:0] a);
    logic [7:0] b [4];
    logic [31:0] w;
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = be ? bbe[(int'(a[9:0]) + i) % 1024] : ble[(int'(a[9:0]) + i) % 1024];
    w = be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    h = be ? {b[0], b[1]} : {b[1], b[0]};
    return op == 6'h23 ? w : op == 6'h20 ? {{24{b[0][7]}}, b[0]} : op == 6'h24 ? {24'b0, b[0]} :
           op == 6'h21 ? {{16{h[15]}}, h} : {16'b0, h};
  endfunction

  task automatic st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int n = op == 6'h2B ? 4 : op == 6'h29 ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      ble[int'(a[9:0]) + i] = d[8*i +: 8];
      bbe[int'(a[9:0]) + i] = d[8*(n-1-i) +: 8];
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d, input bit apply = 1'b1);
    int n = 0;
    bit mis;
    @(negedge clk);
    req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!(le_ready && be_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("ready_timeout", {31'b0, le_ready & be_ready}, 32'd1);
    mis = ((op == 6'h21 || op == 6'h25 || op == 6'h29) && a[0]) ||
          ((op == 6'h23 || op == 6'h2B) && a[1:0] != 2'b00);
    if (mis) mq.push_back(exp_t'{$sformatf("mis_%h", a), cyc + 1, a, a});
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25})
      rq.push_back(exp_t'{$sformatf("op%h@%h", op, a), cyc + 1, ld(1'b0, op, a), ld(1'b1, op, a)});
    else if (apply && op inside {6'h28, 6'h29, 6'h2B}) st(op, a, d);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic chk_reset(input string t);
    check({t, "_ready_le"}, {31'b0, le_ready}, 32'd1);
    check({t, "_ready_be"}, {31'b0, be_ready}, 32'd1);
    check({t, "_rv"}, {30'b0, le_rv, be_rv}, 32'd0);
    check({t, "_rdata_le"}, le_rdata, 32'd0);
    check({t, "_rdata_be"}, be_rdata, 32'd0);
    check({t, "_mis"}, {30'b0, le_mis, be_mis}, 32'd0);
    check({t, "_maddr_le"}, le_maddr, 32'd0);
    check({t, "_maddr_be"}, be_maddr, 32'd0);
  endtask

  // scoreboard: pop expected load results and misalign pulses as the DUTs produce them
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (le_rv || be_rv) begin
        if (rq.size() == 0) check("unexpected_rdata_valid", {31'b0, le_rv | be_rv}, 32'd0);
        else begin
          e = rq.pop_front();
          check({e.tag, "_latency"}, cyc, e.cyc);
          check({e.tag, "_le"}, le_rdata, e.le);
          check({e.tag, "_be"}, be_rdata, e.be);
          check({e.tag, "_rv_both"}, {31'b0, le_rv & be_rv}, 32'd1);
          check({e.tag, "_ready_low"}, {31'b0, le_ready | be_ready}, 32'd0);
        end
      end
      if (le_mis || be_mis) begin
        if (mq.size() == 0) check("unexpected_misalign", {31'b0, le_mis | be_mis}, 32'd0);
        else begin
          e = mq.pop_front();
          check({e.tag, "_latency"}, cyc, e.cyc);
          check({e.tag, "_addr_le"}, le_maddr, e.le);
          check({e.tag, "_addr_be"}, be_maddr, e.be);
          check({e.tag, "_both"}, {31'b0, le_mis & be_mis}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    send(6'h2B, 32'h010, 32'h11223344);
    send(6'h23, 32'h010, 0);
    send(6'h28, 32'h012, 32'h000000AB);
    send(6'h23, 32'h010, 0);
    send(6'h20, 32'h012, 0);
    send(6'h24, 32'h012, 0);
    send(6'h29, 32'h012, 32'h00008001);
    send(6'h21, 32'h012, 0);
    send(6'h25, 32'h012, 0);
    send(6'h23, 32'h010, 0);
    send(6'h2B, 32'h000, 32'h11223344);
    send(6'h20, 32'h000, 0);
    send(6'h24, 32'h003, 0);
    send(6'h25, 32'h000, 0);
    send(6'h23, 32'h011, 0);
    send(6'h29, 32'h013, 32'h0000FFFF);
    send(6'h23, 32'h010, 0);
    send(6'h21, 32'h001, 0);
    send(6'h25, 32'h003, 0);
    send(6'h2B, 32'h012, 32'hDEADBEEF);
    send(6'h00, 32'h010, 32'h12345678);
    send(6'h2C, 32'h010, 32'h12345678);
    send(6'h23, 32'h010, 0);
    send(6'h2B, 32'h404, 32'hCAFEF00D);
    send(6'h23, 32'h004, 0);
    send(6'h2B, 32'h100, 32'hA5000000);
    c0 = cyc;
    for (int i = 1; i < 8; i++) begin
      send(6'h2B, 32'h100 + 32'(4 * i), 32'hA5000000 + 32'(i * 32'h01010101));
      check("burst_ready", {31'b0, le_ready & be_ready}, 32'd1);
    end
    check("burst_cycles", cyc, c0 + 7);
    for (int i = 0; i < 8; i++) send(6'h23, 32'h100 + 32'(4 * i), 0);
    send(6'h2B, 32'h020, 32'h55555555);
    send(6'h28, 32'h020, 32'h000000EE, 1'b0);
    rst_n = 1'b0;
    #2 chk_reset("rst_rmw");
    @(negedge clk);
    rst_n = 1'b1;
    send(6'h23, 32'h020, 0);
    send(6'h23, 32'h020, 0);
    rst_n = 1'b0;
    #1 check("rst_load_rv", {30'b0, le_rv, be_rv}, 32'd0);
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(6'h28, 32'h021, 32'h00000077);
    send(6'h23, 32'h020, 0);
    repeat (4) @(negedge clk);
    check("rq_drained", rq.size(), 32'd0);
    check("mq_drained", mq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
